// File: rtl/sd_multiblock_reader.sv
// SPI-mode SD reader: one CMD17 per block over a run of block_count blocks, payload bytes pushed to the frame FIFO.
// Latency: a push follows each 8th payload bit by one SCLK; a block costs GAP+48+R1+token wait+8*BLOCK_BYTES+16+1 cycles.
// Backpressure: holds in WAIT_FIFO with CS low and MOSI idle until fifo_empty; optional CRC check under SD_CRC16_CHECK_EN.
module sd_multiblock_reader #(
    parameter int BLOCK_BYTES   = 512,
    parameter int ADDR_MODE     = 0,
    parameter int CNT_W         = 16,
    parameter int RESP_TIMEOUT  = 64,
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int MAX_RETRY     = 3,
    parameter int GAP_CYCLES    = 8
) (
    input  logic             SCLK,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      start_addr,
    input  logic [CNT_W-1:0] block_count,
    input  logic             MISO,
    output logic             MOSI,
    output logic             CS,
    input  logic             fifo_empty,
    output logic [7:0]       fifo_data_in,
    output logic             fifo_push,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       error_code,
    output logic [CNT_W-1:0] block_index
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_FIFO, S_GAP, S_SEND, S_WAIT_R1, S_CHECK_R1, S_WAIT_TOKEN,
        S_DATA, S_CRC, S_NEXT, S_RETRY, S_DONE, S_ERROR
    } state_t;

    // One shared 16-bit cycle counter covers gap, frame, timeouts and payload bits.
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] RESP_LAST  = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] TOKEN_LAST = 16'(TOKEN_TIMEOUT - 1);
    localparam logic [15:0] DATA_LAST  = 16'(BLOCK_BYTES * 8 - 1);
    localparam logic [31:0] ADDR_STEP  = (ADDR_MODE != 0) ? 32'd1 : 32'(BLOCK_BYTES);
    localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

    state_t             state;
    logic [15:0]        cnt;
    logic [31:0]        addr;
    logic [CNT_W-1:0]   count_lat;
    logic [7:0]         retry;
    logic [2:0]         cause;
    logic [47:0]        frame_sr;
    logic [7:0]         r1_sr;
    logic               r1_started;
    logic [7:0]         shift8;
`ifdef SD_CRC16_CHECK_EN
    logic [15:0]        crc_calc;
    logic [15:0]        crc_rx;
`endif

    logic [47:0]        cmd_frame;
    logic [7:0]         shift_in;
    logic [CNT_W-1:0]   bidx_inc;
    logic [1:0]         retry_sat;

    assign cmd_frame = {8'h51, addr, 8'hFF};
    assign shift_in  = {shift8[6:0], MISO};
    assign bidx_inc  = block_index + CNT_W'(1);
    assign retry_sat = (retry > 8'd3) ? 2'd3 : retry[1:0];

    // Main sequencer: command framing, response/token hunt, payload streaming, retry and run bookkeeping.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr         <= '0;
            count_lat    <= '0;
            retry        <= '0;
            cause        <= '0;
            frame_sr     <= '0;
            r1_sr        <= '0;
            r1_started   <= 1'b0;
            shift8       <= 8'hFF;
            MOSI         <= 1'b1;
            CS           <= 1'b1;
            fifo_data_in <= '0;
            fifo_push    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            error_code   <= '0;
            block_index  <= '0;
`ifdef SD_CRC16_CHECK_EN
            crc_calc     <= '0;
            crc_rx       <= '0;
`endif
        end else begin
            fifo_push <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        addr        <= start_addr;
                        count_lat   <= block_count;
                        block_index <= '0;
                        retry       <= '0;
                        error_code  <= '0;
                        error       <= 1'b0;
                        MOSI        <= 1'b1;
                        if (block_count == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            CS    <= 1'b1;
                        end else begin
                            state <= S_WAIT_FIFO;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                            CS    <= 1'b0;
                        end
                    end
                end
                S_WAIT_FIFO: begin
                    MOSI <= 1'b1;
                    cnt  <= '0;
                    if (fifo_empty) state <= S_GAP;
                end
                S_GAP: begin
                    // Load the frame on the last idle cycle so bit 47 is on the wire for the first SEND cycle.
                    if (cnt == GAP_LAST) begin
                        MOSI     <= cmd_frame[47];
                        frame_sr <= {cmd_frame[46:0], 1'b0};
                        cnt      <= '0;
                        state    <= S_SEND;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_SEND: begin
                    if (cnt == 16'd47) begin
                        MOSI       <= 1'b1;
                        cnt        <= '0;
                        r1_started <= 1'b0;
                        state      <= S_WAIT_R1;
                    end else begin
                        MOSI     <= frame_sr[47];
                        frame_sr <= {frame_sr[46:0], 1'b0};
                        cnt      <= cnt + 16'd1;
                    end
                end
                S_WAIT_R1: begin
                    r1_sr <= {r1_sr[6:0], MISO};
                    if (!r1_started) begin
                        if (!MISO) begin
                            r1_started <= 1'b1;
                            cnt        <= '0;
                        end else if (cnt == RESP_LAST) begin
                            cause <= 3'd1;
                            state <= S_RETRY;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else begin
                        // Seven more bits follow the start bit.
                        if (cnt == 16'd6) state <= S_CHECK_R1;
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CHECK_R1: begin
                    if (r1_sr == 8'h00) begin
                        shift8 <= 8'hFF;
                        cnt    <= '0;
                        state  <= S_WAIT_TOKEN;
                    end else begin
                        cause <= 3'd2;
                        state <= S_RETRY;
                    end
                end
                S_WAIT_TOKEN: begin
                    shift8 <= shift_in;
                    if (shift_in == 8'hFE) begin
                        cnt   <= '0;
                        state <= S_DATA;
`ifdef SD_CRC16_CHECK_EN
                        crc_calc <= '0;
`endif
                    end else if (shift_in[7:4] == 4'h0 || cnt == TOKEN_LAST) begin
                        // A data error token is handled like a missing token.
                        cause <= 3'd3;
                        state <= S_RETRY;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    shift8 <= shift_in;
`ifdef SD_CRC16_CHECK_EN
                    crc_calc <= {crc_calc[14:0], 1'b0} ^
                                ((crc_calc[15] ^ MISO) ? 16'h1021 : 16'h0000);
`endif
                    if (cnt[2:0] == 3'd7) begin
                        fifo_data_in <= shift_in;
                        fifo_push    <= 1'b1;
                    end
                    if (cnt == DATA_LAST) begin
                        cnt   <= '0;
                        state <= S_CRC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_CRC: begin
`ifdef SD_CRC16_CHECK_EN
                    crc_rx <= {crc_rx[14:0], MISO};
`endif
                    if (cnt == 16'd15) begin
                        cnt   <= '0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_NEXT: begin
`ifdef SD_CRC16_CHECK_EN
                    if (crc_rx != crc_calc) begin
                        cause <= 3'd4;
                        state <= S_RETRY;
                    end else
`endif
                    begin
                        block_index <= bidx_inc;
                        addr        <= addr + ADDR_STEP;
                        retry       <= '0;
                        if (bidx_inc == count_lat) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            CS    <= 1'b1;
                            MOSI  <= 1'b1;
                        end else begin
                            state <= S_WAIT_FIFO;
                        end
                    end
                end
                S_RETRY: begin
                    // Same address is reissued; bytes already pushed stay in the FIFO.
                    if (retry < RETRY_MAX) begin
                        retry <= retry + 8'd1;
                        state <= S_WAIT_FIFO;
                    end else begin
                        state      <= S_ERROR;
                        error      <= 1'b1;
                        busy       <= 1'b0;
                        CS         <= 1'b1;
                        MOSI       <= 1'b1;
                        error_code <= {3'b000, cause, retry_sat};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_multiblock_reader.sv
// Bench for sd_multiblock_reader: table of whole-run vectors against a card model, plus stall and reset sequences.
// Card answers every CMD17 with an R1, a token after a fixed delay, a 0x00..0xFF pattern and a CCITT CRC.
// Every pushed byte is scored against the bytes the card has sent.
module tb_sd_multiblock_reader;

    logic        SCLK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] block_count = '0;
    logic        MISO = 1'b1;
    logic        MOSI;
    logic        CS;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data_in;
    logic        fifo_push;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  error_code;
    logic [15:0] block_index;

    sd_multiblock_reader dut (
        .SCLK(SCLK), .reset(reset), .start(start), .start_addr(start_addr),
        .block_count(block_count), .MISO(MISO), .MOSI(MOSI), .CS(CS),
        .fifo_empty(fifo_empty), .fifo_data_in(fifo_data_in), .fifo_push(fifo_push),
        .busy(busy), .done(done), .error(error), .error_code(error_code),
        .block_index(block_index)
    );

    always #5 SCLK = ~SCLK;

    int tests = 0;
    int fails = 0;

    // Card model state
    bit          miso_q[$];
    logic [7:0]  exp_bytes[$];
    logic [47:0] frames[$];
    int          push_count = 0;
    int          r1_bad_left = 0;
    bit          silent = 1'b0;
    int          token_delay = 20;
    logic [47:0] rx = '0;
    int          rx_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void queue_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) miso_q.push_back(b[i]);
    endfunction

    function automatic void build_response();
        logic [15:0] crc;
        logic [7:0]  b;
        if (silent) return;
        miso_q.push_back(1'b1);
        miso_q.push_back(1'b1);
        if (r1_bad_left > 0) begin
            r1_bad_left--;
            queue_byte(8'h05);
            return;
        end
        queue_byte(8'h00);
        for (int i = 0; i < token_delay; i++) miso_q.push_back(1'b1);
        queue_byte(8'hFE);
        crc = '0;
        for (int i = 0; i < 512; i++) begin
            b = 8'(i);
            exp_bytes.push_back(b);
            for (int j = 7; j >= 0; j--) begin
                miso_q.push_back(b[j]);
                crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ b[j]) ? 16'h1021 : 16'h0000);
            end
        end
        for (int j = 15; j >= 0; j--) miso_q.push_back(crc[j]);
    endfunction

    // Card: drive MISO and parse command frames on the falling edge.
    initial forever begin
        @(negedge SCLK);
        if (!reset) begin
            miso_q.delete();
            exp_bytes.delete();
            rx_n = 0;
            MISO = 1'b1;
        end else begin
            if (miso_q.size() > 0) MISO = miso_q.pop_front();
            else MISO = 1'b1;
            if (rx_n > 0) begin
                rx = {rx[46:0], MOSI};
                rx_n++;
                if (rx_n == 48) begin
                    frames.push_back(rx);
                    rx_n = 0;
                    build_response();
                end
            end else if (!CS && !MOSI) begin
                rx   = '0;
                rx_n = 1;
            end
        end
    end

    // Push scoreboard
    initial forever begin
        @(negedge SCLK);
        if (reset && fifo_push) begin
            push_count++;
            if (exp_bytes.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL push_unexpected: got 0x%0h expected no push", fifo_data_in);
            end else begin
                check($sformatf("push_data_%0d", push_count), fifo_data_in, exp_bytes.pop_front());
            end
        end
    end

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
        @(negedge SCLK);
        start_addr  = a;
        block_count = n;
        start       = 1'b1;
        @(negedge SCLK);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int k = 0;
        while (!(done || error) && k < 30000) begin
            @(negedge SCLK);
            k++;
        end
        if (!(done || error)) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done/error expected done or error within 30000 cycles", name);
        end
    endtask

    task automatic wait_pushes(input string name, input int n);
        int k = 0;
        while (push_count < n && k < 20000) begin
            @(negedge SCLK);
            k++;
        end
        if (push_count < n) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pushes expected %0d", name, push_count, n);
        end
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic [15:0]      cnt;
        int               r1_bad;
        bit               sil;
        int               exp_frames;
        int               exp_pushes;
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_code;
        logic [15:0]      exp_bidx;
        logic [3:0][31:0] exp_fa;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [15:0] n, input int rb, input bit sil,
                                input int nf, input int np, input logic d, input logic e,
                                input logic [7:0] c, input logic [15:0] bi,
                                input logic [31:0] f0, input logic [31:0] f1,
                                input logic [31:0] f2, input logic [31:0] f3);
        vec_t v;
        v.addr = a; v.cnt = n; v.r1_bad = rb; v.sil = sil;
        v.exp_frames = nf; v.exp_pushes = np; v.exp_done = d; v.exp_err = e;
        v.exp_code = c; v.exp_bidx = bi; v.exp_fa = {f3, f2, f1, f0};
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        vecs[0] = mk(32'h0, 16'd1, 0, 1'b0, 1, 512, 1'b1, 1'b0, 8'h00, 16'd1,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1] = mk(32'h400, 16'd3, 0, 1'b0, 3, 1536, 1'b1, 1'b0, 8'h00, 16'd3,
                     32'h400, 32'h600, 32'h800, 32'h0);
        vecs[2] = mk(32'h1000, 16'd1, 1, 1'b0, 2, 512, 1'b1, 1'b0, 8'h00, 16'd1,
                     32'h1000, 32'h1000, 32'h0, 32'h0);
        vecs[3] = mk(32'h20, 16'd2, 0, 1'b1, 4, 0, 1'b0, 1'b1, 8'h07, 16'd0,
                     32'h20, 32'h20, 32'h20, 32'h20);
        vecs[4] = mk(32'h5, 16'd0, 0, 1'b0, 0, 0, 1'b1, 1'b0, 8'h00, 16'd0,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(32'hFFFF_FE00, 16'd2, 0, 1'b0, 2, 1024, 1'b1, 1'b0, 8'h00, 16'd2,
                     32'hFFFF_FE00, 32'h0, 32'h0, 32'h0);

        // Reset values
        repeat (3) @(negedge SCLK);
        check("rst_cs", CS, 1'b1);
        check("rst_mosi", MOSI, 1'b1);
        check("rst_push", fifo_push, 1'b0);
        check("rst_data", fifo_data_in, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_code", error_code, 8'h00);
        check("rst_bidx", block_index, 16'd0);
        reset = 1'b1;
        repeat (2) @(negedge SCLK);

        // Table-driven whole runs
        for (int i = 0; i < 6; i++) begin
            frames.delete();
            exp_bytes.delete();
            push_count  = 0;
            r1_bad_left = vecs[i].r1_bad;
            silent      = vecs[i].sil;
            pulse_start(vecs[i].addr, vecs[i].cnt);
            wait_end($sformatf("v%0d", i));
            @(negedge SCLK);
            check($sformatf("v%0d_done", i), done, vecs[i].exp_done);
            check($sformatf("v%0d_error", i), error, vecs[i].exp_err);
            check($sformatf("v%0d_code", i), error_code, vecs[i].exp_code);
            check($sformatf("v%0d_bidx", i), block_index, vecs[i].exp_bidx);
            check($sformatf("v%0d_busy", i), busy, 1'b0);
            check($sformatf("v%0d_cs", i), CS, 1'b1);
            check($sformatf("v%0d_frames", i), frames.size(), vecs[i].exp_frames);
            check($sformatf("v%0d_pushes", i), push_count, vecs[i].exp_pushes);
            check($sformatf("v%0d_bytes_left", i), exp_bytes.size(), 0);
            for (int f = 0; f < frames.size() && f < 4; f++)
                check($sformatf("v%0d_frame%0d", i, f), frames[f],
                      {8'h51, vecs[i].exp_fa[f], 8'hFF});
        end
        silent = 1'b0;

        // FIFO stall before block 2; a start while busy must be ignored
        frames.delete();
        exp_bytes.delete();
        push_count = 0;
        pulse_start(32'h2000, 16'd2);
        wait_pushes("stall_first_block", 512);
        fifo_empty = 1'b0;
        pulse_start(32'h9999, 16'd5);
        begin
            int bad = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge SCLK);
                if (MOSI !== 1'b1 || CS !== 1'b0) bad++;
            end
            check("stall_idle_bus_cycles", bad, 0);
        end
        check("stall_frames", frames.size(), 1);
        check("stall_busy", busy, 1'b1);
        check("stall_bidx", block_index, 16'd1);
        fifo_empty = 1'b1;
        wait_end("stall");
        @(negedge SCLK);
        check("stall_done", done, 1'b1);
        check("stall_bidx_end", block_index, 16'd2);
        check("stall_pushes", push_count, 1024);
        check("stall_frames_end", frames.size(), 2);
        if (frames.size() >= 2)
            check("stall_frame1", frames[1], {8'h51, 32'h2200, 8'hFF});
        check("stall_bytes_left", exp_bytes.size(), 0);

        // Reset in the middle of the payload, then a clean rerun
        frames.delete();
        exp_bytes.delete();
        push_count = 0;
        pulse_start(32'h300, 16'd1);
        wait_pushes("rst_mid", 200);
        reset = 1'b0;
        #1;
        check("rstmid_cs", CS, 1'b1);
        check("rstmid_push", fifo_push, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_mosi", MOSI, 1'b1);
        check("rstmid_bidx", block_index, 16'd0);
        repeat (3) @(negedge SCLK);
        reset = 1'b1;
        frames.delete();
        exp_bytes.delete();
        push_count = 0;
        pulse_start(32'h300, 16'd1);
        wait_end("rerun");
        @(negedge SCLK);
        check("rerun_done", done, 1'b1);
        check("rerun_error", error, 1'b0);
        check("rerun_pushes", push_count, 512);
        check("rerun_frames", frames.size(), 1);
        if (frames.size() >= 1)
            check("rerun_frame0", frames[0], {8'h51, 32'h300, 8'hFF});
        check("rerun_bytes_left", exp_bytes.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_multiblock_reader.md
Name: sd_multiblock_reader

Overview:
- SPI-mode SD card reader. Issues one CMD17 (single-block read) per block for a run of N consecutive blocks.
- Hunts for the R1 response and the data token, then streams each payload byte into the downstream byte FIFO.
- Adds over the earlier fixed-count reader: run-time start address and block count, byte/block addressing, response/token timeouts, bounded retry, error reporting, real payload data.
- Sits between the SPI pins (card already initialised) and the frame FIFO; driven by SCLK.

Parameters:
- BLOCK_BYTES, 512, payload bytes per block (power of two, 16..512).
- ADDR_MODE, 0, 0 = byte addressing (address += BLOCK_BYTES per block); 1 = block addressing (address += 1).
- CNT_W, 16, width of block_count / block_index.
- RESP_TIMEOUT, 64, max SCLK cycles waiting for R1 start bit.
- TOKEN_TIMEOUT, 4096, max SCLK cycles waiting for data token 0xFE.
- MAX_RETRY, 3, re-issues of CMD17 per block before error.
- GAP_CYCLES, 8, idle cycles (CS low, MOSI=1) before each command.

Ports:
- SCLK  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle pulse; accepted only in IDLE.
- start_addr  input  32  first card address, latched on accepted start.
- block_count  input  CNT_W  blocks to read, latched on start; 0 → immediate DONE.
- MISO  input  1  card data out, sampled on posedge.
- MOSI  output  1  card data in.
- CS  output  1  chip select, active-low.
- fifo_empty  input  1  FIFO can accept a whole block.
- fifo_data_in  output  8  payload byte.
- fifo_push  output  1  one-cycle write strobe.
- busy  output  1  high in every state except IDLE, DONE, ERROR.
- done  output  1  high while in DONE.
- error  output  1  high while in ERROR.
- error_code  output  8  {3'b0, cause[2:0], retries[1:0]} (retries saturates at 3); cause: 1 = R1 timeout, 2 = R1 nonzero, 3 = token timeout, 4 = CRC mismatch.
- block_index  output  CNT_W  blocks completed in current run.

Behaviour:
- Reset: state IDLE; CS=1, MOSI=1, fifo_push=0, fifo_data_in=0, busy=done=error=0, error_code=0, block_index=0, address=0, retry=0.
- IDLE: on start, latch inputs → WAIT_FIFO; if block_count==0 → DONE.
- WAIT_FIFO: CS=0, MOSI=1; stay until fifo_empty=1, then → GAP.
- GAP: GAP_CYCLES cycles of MOSI=1 → SEND.
- SEND: shift 48-bit frame MSB first, one bit per cycle, exactly 48 cycles: 0x51, address[31:0], 0xFF.
- WAIT_R1: MOSI=1; first MISO=0 sample is R1 bit7; collect 8 bits total.
  - No 0 within RESP_TIMEOUT cycles → retry path, cause 1.
- CHECK_R1 (1 cycle): R1==0x00 → WAIT_TOKEN; else retry path, cause 2.
- WAIT_TOKEN: 8-bit sliding shift of MISO; ==0xFE → DATA.
  - Sampled 0xFF→0x0? error token (upper nibble 0) also treated as token timeout.
  - Timeout after TOKEN_TIMEOUT cycles → retry path, cause 3.
- DATA: BLOCK_BYTES×8 cycles, MSB first.
  - After each 8th bit, fifo_data_in=byte and fifo_push=1 for exactly that one cycle (push aligned with byte completion, no skew).
- CRC: 16 cycles capturing CRC → NEXT.
- NEXT (1 cycle): block_index+1, address advances per ADDR_MODE (32-bit wrap), retry=0.
  - block_index==block_count → DONE; else → WAIT_FIFO.
- Retry path: retry<MAX_RETRY → retry+1, → WAIT_FIFO (same address); else → ERROR with error_code.
  - Bytes already pushed for a failed block are not retracted; downstream discards on error.
- DONE/ERROR: CS=1, MOSI=1; held until next start, which begins a fresh run (block_index, retry, error_code cleared).
- start ignored while busy.
- Reset asserted mid-transfer: immediate return to reset values; push aborts the same instant.

Optional Feature:
- SD_CRC16_CHECK_EN defined:
  - CRC-16-CCITT (poly 0x1021, init 0) computed over DATA bits, compared in NEXT.
  - Mismatch → retry path, cause 4.
- Undefined: CRC bits clocked and discarded; no CRC logic synthesised; cause 4 never produced.

Test Plan:
- Single block: start_addr=0, block_count=1, card model R1=0x00, token after 20 cycles, bytes 0x00..0xFF repeating → 512 pushes matching pattern; frame 0x51_00000000_FF; done=1; block_index=1.
- Three blocks, ADDR_MODE=0, start_addr=0x400 → frames carry 0x400, 0x600, 0x800; 1536 pushes; done.
- R1=0x05 on first attempt then 0x00 → one extra CMD17 with same address; block completes; error=0.
- MISO held 1 forever, MAX_RETRY=3 → 4 CMD17 frames, error=1, error_code=0x07 (cause 1, retries saturated).
- fifo_empty low 100 cycles before block 2 → no MOSI activity during wait; resumes after rise; no lost bytes.
- Reset low during byte 200 of DATA → CS=1, fifo_push=0, busy=0 immediately; new start reads from start_addr cleanly.
